clk_strobe_gen: RTL and testbench
=================================

CLK_STROBE_GEN -- requirements
Module: clk_strobe_gen

Interface
REQ-001 SHALL have parameter NCH, default 3, number of strobe channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of per-channel divide/phase fields.
REQ-003 SHALL have port clk_in  input  1  the single clock; all logic is in this domain.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  run request; low forces IDLE.
REQ-006 SHALL have port sync_in  input  1  single-cycle alignment pulse.
REQ-007 SHALL have port div  input  NCH*CNT_W  per-channel period in cycles; channel i uses bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port phase  input  NCH*CNT_W  per-channel strobe offset in cycles, with the same slicing as div.
REQ-009 SHALL have port stb  output  NCH  one-cycle strobe per channel.
REQ-010 SHALL have port clk_o  output  NCH  registered square-wave clock per channel.
REQ-011 SHALL have port locked  output  1  high while in RUN.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on a misaligned sync.

Function
REQ-013 SHALL implement FSM states IDLE, ALIGN and RUN.
REQ-014 IDLE: counters=0, stb=0, clk_o=0, locked=0; enable=1 -> ALIGN on next edge.
REQ-015 ALIGN: waits for sync_in; on sync_in, SHALL load div/phase into shadow registers, clear all counters, enter RUN.
REQ-016 sync_in arriving in the same cycle that enable rises in IDLE SHALL be ignored; only a sync in ALIGN starts RUN.
REQ-017 enable=0 in any state -> IDLE on next edge, outputs 0 in the following cycle.
REQ-018 RUN: per-channel counter increments each cycle and wraps from div_sh-1 to 0.
REQ-019 At each channel's wrap, SHALL reload that channel's shadow div/phase; changes mid-period take effect only at the wrap.
REQ-020 stb[i] SHALL be registered: high for one cycle, phase_sh+1 cycles after the edge that sampled sync_in, then every div_sh cycles.
REQ-021 phase_sh >= div_sh SHALL be treated as div_sh-1.
REQ-022 div_sh=0 SHALL disable the channel: stb=0, clk_o=0, counter held at 0.
REQ-023 div_sh=1: stb high every cycle in RUN, phase ignored.
REQ-024 clk_o[i] SHALL be high while counter < (div_sh+1)>>1, with the same one-cycle register latency as stb.
REQ-025 sync_in in RUN with every enabled counter already 0: SHALL have no effect on counters.
REQ-026 sync_in in RUN otherwise: SHALL clear all counters, reload shadows, and pulse sync_err one cycle later.
REQ-027 Simultaneous wrap and sync_in: sync action SHALL take precedence.
REQ-028 locked SHALL be 1 from the first cycle the FSM is in RUN until it leaves RUN.

Reset
REQ-029 reset_n low SHALL asynchronously force: FSM=IDLE; counters, shadows, stb, clk_o, locked and sync_err all 0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately; after release the block restarts through ALIGN.

Configuration
REQ-031 With macro CLK_STROBE_GEN_DUTY_EN defined, clk_o SHALL be generated per REQ-024.
REQ-032 Without CLK_STROBE_GEN_DUTY_EN, clk_o SHALL be tied to 0 and its registers omitted; stb behaviour SHALL be unchanged.

Structure
REQ-033 Package clk_strobe_pkg SHALL hold the FSM state enum and the default NCH and CNT_W constants.
REQ-034 Per-channel counter, shadow and decode logic SHALL be a sub-module clk_strobe_chan, instantiated NCH times.

Verification
REQ-035 NCH=3, div={4,5,10}, phase={0,2,9}, enable then sync -> stb0 at +1 then every 4; stb1 at +3 then every 5; stb2 at +10 then every 10; locked=1.
REQ-036 RUN with div0 changed 4->6 mid-period -> current period stays 4 cycles; next and later periods are 6.
REQ-037 sync at counter=2 (div=4) -> counters cleared, sync_err pulse one cycle later; a second sync when all counters are 0 -> no sync_err.
REQ-038 div=0 on ch1, div=1 on ch2 -> stb1=0 and clk_o1=0; stb2=1 every RUN cycle.
REQ-039 reset_n low mid-RUN -> all outputs 0 immediately; after release, enable=1 with no sync keeps locked=0.
REQ-040 div=5 with DUTY_EN -> clk_o high 3 cycles, low 2; without DUTY_EN -> clk_o stays 0.

Source files
------------

// File: rtl/clk_strobe_pkg.sv
// Shared types and defaults for the clk_strobe_gen strobe/clock generator.
// Optional duty-cycle clock outputs are enabled with CLK_STROBE_GEN_DUTY_EN.
package clk_strobe_pkg;

  localparam int DEF_NCH   = 3;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/clk_strobe_gen_if.sv
// Bundle of the clk_strobe_gen control and status signals.
// The master side drives configuration and sync; the slave side is the generator.
interface clk_strobe_gen_if #(
  parameter int NCH   = clk_strobe_pkg::DEF_NCH,
  parameter int CNT_W = clk_strobe_pkg::DEF_CNT_W
);

  logic                 enable;
  logic                 sync_in;
  logic [NCH*CNT_W-1:0] div;
  logic [NCH*CNT_W-1:0] phase;
  logic [NCH-1:0]       stb;
  logic [NCH-1:0]       clk_o;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output enable, sync_in, div, phase,
    input  stb, clk_o, locked, sync_err
  );

  modport slave (
    input  enable, sync_in, div, phase,
    output stb, clk_o, locked, sync_err
  );

endinterface

// File: rtl/clk_strobe_chan.sv
// One strobe channel: period counter, shadowed div/phase and output decode.
// The registered square-wave output exists only with CLK_STROBE_GEN_DUTY_EN.
module clk_strobe_chan #(
  parameter int CNT_W = clk_strobe_pkg::DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] phase_in,
  output logic             stb,
  output logic             clk_o,
  output logic             at_zero
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_sh;
  logic [CNT_W-1:0] phase_sh;
  logic [CNT_W-1:0] phase_eff;
  logic             enabled;
  logic             wrap;
  logic             hit;
  logic             stb_q;

  // Decode wrap and strobe position; an out-of-range phase lands on the last count.
  always_comb begin
    enabled   = (div_sh != '0);
    wrap      = enabled && (count == div_sh - CNT_W'(1));
    phase_eff = (phase_sh >= div_sh) ? div_sh - CNT_W'(1) : phase_sh;
    hit       = enabled && (count == phase_eff);
    at_zero   = !enabled || (count == '0);
  end

  // Counter and shadows: a sync load beats a wrap, and shadows only move at a boundary.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      div_sh   <= '0;
      phase_sh <= '0;
    end else if (load) begin
      count    <= '0;
      div_sh   <= div_in;
      phase_sh <= phase_in;
    end else if (run) begin
      if (wrap) begin
        count    <= '0;
        div_sh   <= div_in;
        phase_sh <= phase_in;
      end else if (enabled) begin
        count <= count + CNT_W'(1);
      end
    end else begin
      count <= '0;
    end
  end

  // Strobe is registered from the counter value of the current cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= run && hit;
    end
  end

  assign stb = stb_q;

`ifdef CLK_STROBE_GEN_DUTY_EN
  logic [CNT_W:0] half;
  logic           clk_q;

  assign half = ({1'b0, div_sh} + (CNT_W+1)'(1)) >> 1;

  // Square wave is high for the first half (rounded up) of each period.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= run && enabled && ({1'b0, count} < half);
    end
  end

  assign clk_o = clk_q;
`else
  assign clk_o = 1'b0;
`endif

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel strobe and clock generator with sync alignment.
// Define CLK_STROBE_GEN_DUTY_EN to build the per-channel clk_o square waves.
module clk_strobe_gen
  import clk_strobe_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sync_in,
  input  logic [NCH*CNT_W-1:0] div,
  input  logic [NCH*CNT_W-1:0] phase,
  output logic [NCH-1:0]       stb,
  output logic [NCH-1:0]       clk_o,
  output logic                 locked,
  output logic                 sync_err
);

  state_t         state;
  state_t         state_nx;
  logic [NCH-1:0] at_zero;
  logic           all_zero;
  logic           run;
  logic           load;
  logic           misaligned;
  logic           sync_err_q;

  // Sequencing: IDLE -> ALIGN on enable, ALIGN -> RUN on sync, dropping enable always idles.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_ALIGN;
      ST_ALIGN: begin
        if (!enable) state_nx = ST_IDLE;
        else if (sync_in) state_nx = ST_RUN;
      end
      ST_RUN:   if (!enable) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Channel control: a sync already lined up with every channel is harmless in RUN.
  always_comb begin
    all_zero   = &at_zero;
    run        = (state == ST_RUN) && enable;
    misaligned = run && sync_in && !all_zero;
    load       = (enable && sync_in && (state == ST_ALIGN)) || misaligned;
  end

  // Error pulse lands the cycle after the offending sync.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= misaligned;
    end
  end

  assign sync_err = sync_err_q;
  assign locked   = (state == ST_RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_strobe_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .run      (run),
      .load     (load),
      .div_in   (div[i*CNT_W +: CNT_W]),
      .phase_in (phase[i*CNT_W +: CNT_W]),
      .stb      (stb[i]),
      .clk_o    (clk_o[i]),
      .at_zero  (at_zero[i])
    );
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed self-checking bench for clk_strobe_gen (NCH=3, CNT_W=8).
// Expectations for clk_o follow CLK_STROBE_GEN_DUTY_EN as compiled.
module tb_clk_strobe_gen;

  logic clk_in;
  logic reset_n;
  int   n_checks;
  int   n_fails;
  int   div_m[3];
  int   ph_m[3];

  clk_strobe_gen_if #(.NCH(3), .CNT_W(8)) bus ();

  clk_strobe_gen #(
    .NCH   (3),
    .CNT_W (8)
  ) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .enable   (bus.enable),
    .sync_in  (bus.sync_in),
    .div      (bus.div),
    .phase    (bus.phase),
    .stb      (bus.stb),
    .clk_o    (bus.clk_o),
    .locked   (bus.locked),
    .sync_err (bus.sync_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(int ch, int j, bit chg);
    if (chg && ch == 0) return (j < 24) ? 4 : 6;
    return div_m[ch];
  endfunction

  function automatic int cnt_of(int ch, int j, bit chg);
    int d;
    d = div_of(ch, j, chg);
    if (d == 0) return 0;
    if (chg && ch == 0 && j >= 24) return (j - 24) % 6;
    return j % d;
  endfunction

  // k counts edges since the edge that loaded the counters.
  task automatic run_and_check(input int first_k, input int n, input bit chg);
    logic [2:0] es;
    logic [2:0] ec;
    for (int k = first_k; k < first_k + n; k++) begin
      step();
      for (int ch = 0; ch < 3; ch++) begin
        int d;
        int c;
        int pe;
        d  = div_of(ch, k - 1, chg);
        c  = cnt_of(ch, k - 1, chg);
        pe = (ph_m[ch] >= d) ? d - 1 : ph_m[ch];
        es[ch] = (d != 0) && (c == pe);
        ec[ch] = (d != 0) && (c < (d + 1) / 2);
      end
`ifndef CLK_STROBE_GEN_DUTY_EN
      ec = 3'b000;
`endif
      check_output($sformatf("stb k=%0d", k), 8'(bus.stb), 8'(es));
      check_output($sformatf("clk_o k=%0d", k), 8'(bus.clk_o), 8'(ec));
      check_output($sformatf("locked k=%0d", k), 8'(bus.locked), 8'd1);
      check_output($sformatf("sync_err k=%0d", k), 8'(bus.sync_err), 8'd0);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic sy);
    bus.enable  = en;
    bus.sync_in = sy;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    bus.div   = {8'd10, 8'd5, 8'd4};
    bus.phase = {8'd9, 8'd2, 8'd0};
    div_m = '{4, 5, 10};
    ph_m  = '{0, 2, 9};

    step();
    step();
    check_output("reset stb", 8'(bus.stb), 8'd0);
    check_output("reset clk_o", 8'(bus.clk_o), 8'd0);
    check_output("reset locked", 8'(bus.locked), 8'd0);
    check_output("reset sync_err", 8'(bus.sync_err), 8'd0);

    // sync coinciding with enable rising in IDLE is ignored
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0);
    check_output("align locked a", 8'(bus.locked), 8'd0);
    step();
    step();
    check_output("align locked b", 8'(bus.locked), 8'd0);
    check_output("align stb", 8'(bus.stb), 8'd0);

    // sync in ALIGN starts RUN
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0);
    check_output("run locked", 8'(bus.locked), 8'd1);
    check_output("run stb0", 8'(bus.stb), 8'd0);
    check_output("run sync_err", 8'(bus.sync_err), 8'd0);
    run_and_check(1, 26, 1'b0);

    // misaligned sync with ch0 counter at 2
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0);
    check_output("missync sync_err", 8'(bus.sync_err), 8'd1);
    check_output("missync stb", 8'(bus.stb), 8'd0);
    run_and_check(1, 20, 1'b0);

    // all counters at 0: sync has no effect
    apply_stimulus(1'b1, 1'b1);
    run_and_check(21, 1, 1'b0);
    apply_stimulus(1'b1, 0);

    // ch0 div 4 -> 6 mid-period
    bus.div = {8'd10, 8'd5, 8'd6};
    run_and_check(22, 19, 1'b1);

    // new config: ch0 clamped phase, ch1 disabled, ch2 every cycle
    bus.div   = {8'd1, 8'd0, 8'd3};
    bus.phase = {8'd0, 8'd0, 8'd7};
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0);
    check_output("reload sync_err", 8'(bus.sync_err), 8'd1);
    div_m = '{3, 0, 1};
    ph_m  = '{7, 0, 0};
    run_and_check(1, 12, 1'b0);

    // asynchronous reset mid-RUN
    reset_n = 1'b0;
    #1;
    check_output("async rst stb", 8'(bus.stb), 8'd0);
    check_output("async rst clk_o", 8'(bus.clk_o), 8'd0);
    check_output("async rst locked", 8'(bus.locked), 8'd0);
    check_output("async rst sync_err", 8'(bus.sync_err), 8'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("post rst locked %0d", i), 8'(bus.locked), 8'd0);
      check_output($sformatf("post rst stb %0d", i), 8'(bus.stb), 8'd0);
    end

    // restart, then drop enable
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0);
    check_output("relock locked", 8'(bus.locked), 8'd1);
    check_output("relock sync_err", 8'(bus.sync_err), 8'd0);
    step();
    check_output("relock stb", 8'(bus.stb), 8'b100);
    apply_stimulus(1'b0, 1'b0);
    step();
    check_output("disable locked", 8'(bus.locked), 8'd0);
    check_output("disable stb", 8'(bus.stb), 8'd0);
    check_output("disable clk_o", 8'(bus.clk_o), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
